mem_loader: RTL and testbench

Program loader that sits directly upstream of the CPU test top. It turns a framed byte stream from a UART receiver into 32-bit little-endian words and writes them through the external memory-write port: enable, data and byte address. It holds the CPU in reset for the whole load and releases it only after the last word is written. A malformed or stalled frame parks the block in an error state with the CPU still held.

---
 rtl/mem_loader_pkg.sv | 18 +
 rtl/mem_loader_if.sv | 26 ++
 rtl/mem_loader_timeout.sv | 37 +++
 rtl/mem_loader.sv | 154 +++++++++++++++
 tb/tb_mem_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the UART program loader.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Sync marker plus 16-bit little-endian word count.
  localparam int HDR_LEN = 3;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and external memory-write port of the loader.
// rx_valid is a one-cycle strobe with no back-pressure: every high cycle carries one byte in rx_data.
// ext_mem_write is a one-cycle strobe; ext_write_data/ext_data_adr are valid with it and hold until the next write.
interface mem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ext_mem_write;
  logic [31:0] ext_write_data;
  logic [31:0] ext_data_adr;

  modport master (
    input  rx_data,
    input  rx_valid,
    output ext_mem_write,
    output ext_write_data,
    output ext_data_adr
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  ext_mem_write,
    input  ext_write_data,
    input  ext_data_adr
  );
endinterface

// File: rtl/mem_loader_timeout.sv
// Inter-byte idle counter: cleared by a byte or when disabled, flags the edge it reaches TIMEOUT_CYCLES.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires combinationally so the owner changes state on the very edge the count is reached.
  assign tc_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_loader.sv
// Frame parser that assembles little-endian words from a UART byte stream and writes them
// to memory while holding the CPU in reset; parks in ERROR on oversize count or timeout.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  mem_loader_if.master      bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output state_e            dbg_state
);

  localparam int WIDX_W = $clog2(MAX_WORDS + 1);

  state_e             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [WIDX_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [23:0]        asm_q, asm_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        wadr_q, wadr_d;

  logic               tmo_en;
  logic               tmo;
  logic               is_sync;
  logic [15:0]        rx_len;
  logic               last_written;

  assign tmo_en       = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign is_sync      = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign rx_len       = {bus.rx_data, len_q[7:0]};
  // The final strobe is on the bus now; leaving DATA afterwards keeps the CPU held through it.
  assign last_written = wr_q && (len_q == 16'(word_idx_q));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.rx_valid),
    .en_i  (tmo_en),
    .tc_o  (tmo)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    wadr_d     = wadr_q;
    case (state_q)
      ST_IDLE: begin
        if (is_sync) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (tmo) begin
          state_d = ST_ERROR;
        end else if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_data;
          state_d    = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (tmo) begin
          state_d = ST_ERROR;
        end else if (bus.rx_valid) begin
          len_d = rx_len;
          if (rx_len == 16'd0) begin
            state_d = ST_DONE;
          end else if (32'(rx_len) > MAX_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d    = ST_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (last_written) begin
          state_d = ST_DONE;
        end else if (tmo) begin
          state_d = ST_ERROR;
        end else if (bus.rx_valid) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = bus.rx_data;
            2'd1: asm_d[15:8]  = bus.rx_data;
            2'd2: asm_d[23:16] = bus.rx_data;
            default: begin
              wdata_d    = {bus.rx_data, asm_q};
              wadr_d     = BASE_ADDR + (32'(word_idx_q) << 2);
              wr_d       = 1'b1;
              word_idx_d = word_idx_q + WIDX_W'(1);
            end
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERROR: begin
        if (is_sync) begin
          state_d    = ST_LEN_LO;
          word_idx_d = '0;
          byte_idx_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      wadr_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      wadr_q     <= wadr_d;
    end
  end

  assign bus.ext_mem_write  = wr_q;
  assign bus.ext_write_data = wdata_q;
  assign bus.ext_data_adr   = wadr_q;
  assign cpu_hold           = (state_q != ST_DONE);
  assign done               = (state_q == ST_DONE);
  assign error              = (state_q == ST_ERROR);
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed frames plus random frames against a frame-level model.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 64;
  localparam int          TMO  = 16;

  logic   clk = 1'b0;
  logic   reset;
  logic   cpu_hold, done, error;
  state_e dbg_state;

  mem_loader_if bus();

  mem_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: time %0t, bench expected to finish earlier", $time);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];      // {address, data}
  logic [7:0]  frm_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.ext_mem_write === 1'b1) begin
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      check("wr_cpu_held", 64'(cpu_hold), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("wr_addr_data", {bus.ext_data_adr, bus.ext_write_data}, mon_exp);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    exp_q.delete();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
  endtask

  // Ends #1 after the edge that accepted the final byte.
  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frm_q.size(); i++) begin
      send_byte(frm_q[i]);
      if (i != frm_q.size() - 1 && max_gap > 0) tick($urandom_range(0, max_gap));
    end
  endtask

  // ---------------- reference model ----------------
  // Returns 1 when the frame must end in error, 0 when it loads; queues expected writes.
  function automatic int model_frame(output int cnt);
    int s = 0;
    logic [31:0] w;
    while (frm_q[s] != 8'hA5) s++;
    cnt = int'(frm_q[s+1]) + 256 * int'(frm_q[s+HDR_LEN-1]);
    if (cnt > MAXW) return 1;
    for (int i = 0; i < cnt; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) w = w | (32'(frm_q[s + HDR_LEN + 4*i + k]) << (8*k));
      exp_q.push_back({BASE + 32'(4*i), w});
    end
    return 0;
  endfunction

  // Called #1 after the final byte's edge.
  task automatic finish_check(input string tag, input int is_err, input int cnt);
    if (is_err != 0) begin
      check({tag, "_error"}, 64'(error), 64'd1);
      check({tag, "_hold_err"}, 64'(cpu_hold), 64'd1);
      check({tag, "_done_err"}, 64'(done), 64'd0);
    end else if (cnt == 0) begin
      check({tag, "_done_zero"}, 64'(done), 64'd1);
      check({tag, "_hold_zero"}, 64'(cpu_hold), 64'd0);
    end else begin
      check({tag, "_hold_last"}, 64'(cpu_hold), 64'd1);
      check({tag, "_done_early"}, 64'(done), 64'd0);
      tick(1);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    end
    check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_wr"}, 64'(bus.ext_mem_write), 64'd0);
    check({tag, "_data"}, 64'(bus.ext_write_data), 64'd0);
    check({tag, "_adr"}, 64'(bus.ext_data_adr), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          cnt;
    int          is_err;
    int          r;
    logic [7:0]  b;

    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #1;
    check_reset_vals("por");
    do_reset();
    check_reset_vals("rst");

    // Two-word frame, back to back.
    frm_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back({32'h0000_0000, 32'h1234_5678});
    exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    send_frame(0);
    finish_check("frameA", 0, 2);
    send_byte(8'hA5);
    tick(2);
    check("done_sticky", 64'(done), 64'd1);

    // Leading garbage ignored.
    do_reset();
    frm_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({BASE, 32'h4433_2211});
    send_frame(1);
    finish_check("garbage", 0, 1);

    // Oversize count, then recovery via sync.
    do_reset();
    frm_q = '{8'hA5, 8'h41, 8'h00};
    send_frame(0);
    finish_check("oversize", 1, 0);
    send_byte(8'hA5);
    check("err_cleared", 64'(error), 64'd0);
    frm_q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back({BASE, 32'hEFBE_ADDE});
    send_frame(0);
    finish_check("recover", 0, 1);

    // Stall after two data bytes.
    do_reset();
    frm_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    tick(TMO - 1);
    check("tmo_not_yet", 64'(error), 64'd0);
    tick(1);
    finish_check("timeout", 1, 0);

    // Full-rate three-word frame.
    do_reset();
    frm_q = '{8'hA5, 8'h03, 8'h00};
    for (int i = 0; i < 12; i++) frm_q.push_back(8'($urandom_range(0, 255)));
    is_err = model_frame(cnt);
    send_frame(0);
    finish_check("fullrate", is_err, cnt);

    // Reset mid-frame, then a fresh frame.
    do_reset();
    frm_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame(0);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    tick(1);
    reset = 1'b0;
    send_byte(8'h44);
    frm_q = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q.push_back({BASE, 32'h8877_6655});
    send_frame(0);
    finish_check("after_rst", 0, 1);

    // Random frames against the model.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      frm_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        frm_q.push_back(b);
      end
      r = $urandom_range(0, 9);
      if (r == 0)      cnt = 0;
      else if (r == 1) cnt = MAXW + 1 + $urandom_range(0, 300);
      else if (r == 2) cnt = MAXW;
      else             cnt = $urandom_range(1, 6);
      frm_q.push_back(8'hA5);
      frm_q.push_back(8'(cnt));
      frm_q.push_back(8'(cnt >> 8));
      if (cnt <= MAXW) begin
        for (int i = 0; i < 4 * cnt; i++) frm_q.push_back(8'($urandom_range(0, 255)));
      end
      is_err = model_frame(cnt);
      send_frame(2);
      finish_check($sformatf("rand%0d", t), is_err, cnt);
    end

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
